ping_responder: RTL and testbench
=================================

Name: ping_responder

Overview:
- Emulates an HC-SR04-style ultrasonic ranging sensor: it is the sensor end of the trig/echo protocol that our ping measurement block drives.
- Qualifies an incoming trig pulse, waits a fixed burst delay, then drives echo high for a time proportional to a programmed distance.
- Used on-board in place of a real sensor, and in benches as the stimulus model for ping.

Parameters:
- CLK_FREQ_MHZ, 25, system clock frequency in MHz; 1 us = CLK_FREQ_MHZ cycles.
- MIN_TRIG_US, 10, minimum trig high width accepted.
- BURST_US, 200, delay from trig falling to echo rising.
- US_PER_CM, 58, echo width per cm of distance.
- MAX_CM, 400, largest valid distance.
- TIMEOUT_US, 38000, echo width when distance is invalid (no target).
- HOLDOFF_US, 100, dead time after echo falls before a new trig is accepted.

Ports:
- clk  input  1  system clock
- resetn  input  1  synchronous active-low reset
- trig  input  1  trigger from initiator, asynchronous
- distance_cm  input  9  simulated target distance in cm
- echo  output  1  echo pulse to initiator, registered
- busy  output  1  high in any state other than IDLE
- ping_count  output  8  number of echo pulses issued, wraps 255->0

Behaviour:
- Reset: resetn low on a clk edge gives state=IDLE, echo=0, busy=0, ping_count=0, all counters=0, synchronizer flops=0. This applies from any state; echo mid-pulse drops low on the edge where resetn is sampled low.
- trig passes through a 2-flop synchronizer (trig_s). All behaviour below refers to trig_s.
- A single cycle counter (cnt) is cleared on every state entry. "N us" means cnt reaches N*CLK_FREQ_MHZ-1, i.e. exactly N*CLK_FREQ_MHZ cycles in that state.
- IDLE:
  - trig_s rising (trig_s=1, previous=0) -> TRIG_HI.
- TRIG_HI:
  - cnt counts while trig_s=1 and saturates at MIN_TRIG_US*CLK_FREQ_MHZ.
  - On trig_s=0: if saturated, latch distance_cm into dist_q and go to BURST; otherwise go to IDLE (runt pulse, no echo).
  - A trig held high indefinitely stays in TRIG_HI.
- BURST:
  - After BURST_US, go to ECHO.
  - echo=1 is registered on entry, so echo rises exactly BURST_US*CLK_FREQ_MHZ cycles after the first cycle trig_s is seen low.
- ECHO:
  - echo=1 for W us, then echo=0, ping_count increments (same edge), and state goes to HOLDOFF.
  - W = dist_q*US_PER_CM when 1 <= dist_q <= MAX_CM; W = TIMEOUT_US when dist_q=0 or dist_q>MAX_CM.
  - Compute W*CLK_FREQ_MHZ at full width, no truncation: 38000*25 needs 20 bits; size the counter from the parameters.
- HOLDOFF:
  - After HOLDOFF_US, go to IDLE.
  - If trig_s is already high on return, no rising edge has been seen, so it is ignored until it goes low and high again.
- trig activity in BURST, ECHO or HOLDOFF is ignored.
- distance_cm changes after the latch point do not affect the pulse in flight.
- busy is the registered state != IDLE.

Test Plan:
- Nominal, defaults, distance_cm=10, trig high 12 us: echo rises 5000 cycles after trig_s falls, stays high 14500 cycles, then ping_count=1 and busy drops 2500 cycles after echo falls.
- Runt trig, 5 us (125 cycles): no echo for 2 ms, busy returns to 0, ping_count=0.
- Invalid distance, distance_cm=0 and then 401 on separate pings: echo width 950000 cycles each time; ping_count=2.
- Boundary distance, distance_cm=400 then 1: echo widths 580000 and 1450 cycles.
- Interference: change distance_cm to 50 and pulse trig (12 us) during the ECHO of a 10 cm ping: that echo stays 14500 cycles; no second echo follows. A trig held high across the end of HOLDOFF produces no echo until it is re-pulsed.
- Reset mid-echo: resetn=0 for one cycle 1000 cycles into the echo: echo=0 and busy=0 on that edge, ping_count=0. A following valid 10 cm trig yields a normal 14500-cycle echo.

Source files
------------

// File: rtl/ping_responder.sv
// ping_responder
//   Sensor-side model of an HC-SR04-style ultrasonic ranger. It qualifies a
//   trig pulse and waits a fixed burst delay. It then drives echo high for a
//   time proportional to the programmed distance, or for the no-target
//   timeout when the distance is out of range.
//
// Ports
//   clk          system clock
//   resetn       synchronous active-low reset
//   trig         trigger from the initiator (asynchronous, synchronized here)
//   distance_cm  simulated target distance in cm, latched at trig acceptance
//   echo         echo pulse to the initiator (registered)
//   busy         high whenever the responder is not idle (registered)
//   ping_count   number of echo pulses issued, wraps 255 -> 0
module ping_responder #(
  parameter int unsigned CLK_FREQ_MHZ = 25,
  parameter int unsigned MIN_TRIG_US  = 10,
  parameter int unsigned BURST_US     = 200,
  parameter int unsigned US_PER_CM    = 58,
  parameter int unsigned MAX_CM       = 400,
  parameter int unsigned TIMEOUT_US   = 38000,
  parameter int unsigned HOLDOFF_US   = 100
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       trig,
  input  logic [8:0] distance_cm,
  output logic       echo,
  output logic       busy,
  output logic [7:0] ping_count
);

  localparam int unsigned TRIG_CYC  = MIN_TRIG_US * CLK_FREQ_MHZ;
  localparam int unsigned BURST_CYC = BURST_US * CLK_FREQ_MHZ;
  localparam int unsigned HOLD_CYC  = HOLDOFF_US * CLK_FREQ_MHZ;
  localparam int unsigned TMO_CYC   = TIMEOUT_US * CLK_FREQ_MHZ;
  localparam int unsigned CM_CYC    = US_PER_CM * CLK_FREQ_MHZ;
  localparam int unsigned MAXD_CYC  = MAX_CM * CM_CYC;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // The counter must hold the longest interval spent in any single state.
  localparam int unsigned CNT_MAX = max2(max2(max2(TRIG_CYC, BURST_CYC), HOLD_CYC),
                                         max2(TMO_CYC, MAXD_CYC));
  localparam int unsigned CW = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] TRIG_SAT   = CW'(TRIG_CYC);
  localparam logic [CW-1:0] BURST_LAST = CW'(BURST_CYC - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] TMO_CNT    = CW'(TMO_CYC);
  localparam logic [CW-1:0] CM_CNT     = CW'(CM_CYC);

  typedef enum logic [2:0] {
    IDLE,
    TRIG_HI,
    BURST,
    ECHO,
    HOLDOFF
  } state_e;

  state_e        state_q, state_d;
  logic          sync1_q, trig_s_q, trig_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [8:0]    dist_q, dist_d;
  logic          echo_q, echo_d;
  logic          busy_q, busy_d;
  logic [7:0]    count_q, count_d;

  logic          trig_rise;
  logic          trig_ok;
  logic          dist_valid;
  logic [CW-1:0] echo_cycles;
  logic [CW-1:0] echo_last;

  assign trig_rise  = trig_s_q && !trig_prev_q;
  assign trig_ok    = (cnt_q == TRIG_SAT);
  assign dist_valid = (dist_q != 9'd0) && (32'(dist_q) <= MAX_CM);

  // The product is only used for in-range distances, where it never
  // exceeds CNT_MAX, so CW bits hold it exactly.
  assign echo_cycles = dist_valid ? (CW'(dist_q) * CM_CNT) : TMO_CNT;
  assign echo_last   = echo_cycles - 1'b1;

  // State register, synchronizer and registered outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      sync1_q     <= 1'b0;
      trig_s_q    <= 1'b0;
      trig_prev_q <= 1'b0;
      cnt_q       <= '0;
      dist_q      <= '0;
      echo_q      <= 1'b0;
      busy_q      <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= trig;
      trig_s_q    <= sync1_q;
      // Tracked in every state, so a trig that went high during HOLDOFF is
      // not mistaken for a fresh rising edge back in IDLE.
      trig_prev_q <= trig_s_q;
      cnt_q       <= cnt_d;
      dist_q      <= dist_d;
      echo_q      <= echo_d;
      busy_q      <= busy_d;
      count_q     <= count_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (trig_rise) state_d = TRIG_HI;
      TRIG_HI: if (!trig_s_q) state_d = trig_ok ? BURST : IDLE;
      BURST:   if (cnt_q == BURST_LAST) state_d = ECHO;
      ECHO:    if (cnt_q == echo_last) state_d = HOLDOFF;
      HOLDOFF: if (cnt_q == HOLD_LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counter, distance latch and output next values.
  always_comb begin
    cnt_d   = cnt_q;
    dist_d  = dist_q;
    count_d = count_q;

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q == TRIG_HI) begin
      if (trig_s_q && (cnt_q != TRIG_SAT)) cnt_d = cnt_q + 1'b1;
    end else if (state_q != IDLE) begin
      cnt_d = cnt_q + 1'b1;
    end

    if ((state_q == TRIG_HI) && (state_d == BURST)) dist_d = distance_cm;
    if ((state_q == ECHO) && (state_d == HOLDOFF)) count_d = count_q + 8'd1;

    echo_d = (state_d == ECHO);
    busy_d = (state_d != IDLE);
  end

  assign echo       = echo_q;
  assign busy       = busy_q;
  assign ping_count = count_q;

endmodule

// File: tb/tb_ping_responder.sv
// Testbench for ping_responder. It scales the timing parameters down so that
// long echoes stay short. Directed pings cover the nominal, runt, invalid,
// boundary, interference and reset cases, then randomized pings follow. Each
// observed interval is compared against a reference model of the ranging
// rules.
module tb_ping_responder;

  localparam int unsigned F          = 2;
  localparam int unsigned MIN_TRIG   = 3;
  localparam int unsigned BURST      = 10;
  localparam int unsigned US_CM      = 2;
  localparam int unsigned MAXCM      = 400;
  localparam int unsigned TMO        = 1000;
  localparam int unsigned HOLD       = 5;

  // Raw trig edge to state change: two synchronizer flops plus the FSM edge.
  localparam int unsigned LAT        = 3;
  localparam int unsigned EXP_RISE   = LAT + BURST * F;
  localparam int unsigned EXP_HOLD   = HOLD * F;
  localparam int unsigned LIMIT      = 3000;
  localparam int unsigned QUIET      = EXP_RISE + TMO * F + 50;

  logic       clk = 1'b0;
  logic       resetn;
  logic       trig;
  logic [8:0] distance_cm;
  logic       echo;
  logic       busy;
  logic [7:0] ping_count;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned model_count = 0;

  always #5 clk = ~clk;

  ping_responder #(
    .CLK_FREQ_MHZ(F),
    .MIN_TRIG_US (MIN_TRIG),
    .BURST_US    (BURST),
    .US_PER_CM   (US_CM),
    .MAX_CM      (MAXCM),
    .TIMEOUT_US  (TMO),
    .HOLDOFF_US  (HOLD)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .trig       (trig),
    .distance_cm(distance_cm),
    .echo       (echo),
    .busy       (busy),
    .ping_count (ping_count)
  );

  // Echo width in cycles from the ranging rule.
  function automatic int unsigned exp_width(input int unsigned d);
    if (d >= 1 && d <= MAXCM) return d * US_CM * F;
    return TMO * F;
  endfunction

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits until echo has stayed low for QUIET cycles, then checks the idle state.
  task automatic expect_quiet(input string tag);
    int unsigned n;
    n = 0;
    while (!echo && n < QUIET) begin
      tick();
      n++;
    end
    check_eq({tag, " no echo"}, 32'(echo), 0);
    check_eq({tag, " idle"}, 32'(busy), 0);
    check_eq({tag, " count"}, 32'(ping_count), model_count);
  endtask

  // A full accepted ping: trig high for h cycles, then rise delay, echo width,
  // ping count and holdoff are all measured against the model. If hold_trig is
  // set, trig is raised right after echo falls and left high.
  task automatic valid_ping(input int unsigned d, input int unsigned h,
                            input bit hold_trig, input string tag);
    int unsigned n;
    distance_cm = d[8:0];
    trig = 1'b1;
    repeat (h) tick();
    check_eq({tag, " busy"}, 32'(busy), 1);
    trig = 1'b0;
    n = 0;
    while (!echo && n < LIMIT) begin
      tick();
      n++;
    end
    check_eq({tag, " rise"}, n, EXP_RISE);
    // The distance was latched long ago; changing it must not matter now.
    distance_cm = 9'($urandom_range(0, 511));
    n = 0;
    while (echo && n < LIMIT) begin
      tick();
      n++;
    end
    if (hold_trig) trig = 1'b1;
    check_eq({tag, " width"}, n, exp_width(d));
    model_count = (model_count + 1) % 256;
    check_eq({tag, " count"}, 32'(ping_count), model_count);
    n = 0;
    while (busy && n < LIMIT) begin
      tick();
      n++;
    end
    check_eq({tag, " holdoff"}, n, EXP_HOLD);
  endtask

  task automatic runt_ping(input int unsigned h, input string tag);
    trig = 1'b1;
    repeat (h) tick();
    trig = 1'b0;
    expect_quiet(tag);
  endtask

  initial begin
    int unsigned n;
    resetn      = 1'b0;
    trig        = 1'b0;
    distance_cm = '0;
    repeat (3) tick();
    check_eq("reset echo", 32'(echo), 0);
    check_eq("reset busy", 32'(busy), 0);
    check_eq("reset count", 32'(ping_count), 0);
    resetn = 1'b1;
    tick();

    // Trig widths are kept clearly above (>= 9) or below (<= 4) the
    // MIN_TRIG * F = 6 cycle qualification threshold.
    valid_ping(10, 12 * F, 1'b0, "nominal");
    runt_ping(2 * F, "runt");
    valid_ping(0, 12 * F, 1'b0, "dist0");
    valid_ping(401, 12 * F, 1'b0, "dist401");
    valid_ping(400, 12 * F, 1'b0, "dist400");
    valid_ping(1, 12 * F, 1'b0, "dist1");

    // Interference: trig pulse and distance change during the echo.
    distance_cm = 9'd10;
    trig = 1'b1;
    repeat (12 * F) tick();
    trig = 1'b0;
    n = 0;
    while (!echo && n < LIMIT) begin
      tick();
      n++;
    end
    check_eq("intf rise", n, EXP_RISE);
    n = 0;
    while (echo && n < LIMIT) begin
      if (n == 5) begin
        distance_cm = 9'd50;
        trig = 1'b1;
      end
      if (n == 5 + 12 * F) trig = 1'b0;
      tick();
      n++;
    end
    check_eq("intf width", n, exp_width(10));
    model_count = (model_count + 1) % 256;
    expect_quiet("intf");

    // Trig raised during holdoff and held past it: no new edge, no echo.
    valid_ping(20, 12 * F, 1'b1, "held");
    expect_quiet("held");
    trig = 1'b0;
    repeat (5) tick();
    valid_ping(10, 12 * F, 1'b0, "repulse");

    // Reset mid-echo.
    distance_cm = 9'd300;
    trig = 1'b1;
    repeat (12 * F) tick();
    trig = 1'b0;
    n = 0;
    while (!echo && n < LIMIT) begin
      tick();
      n++;
    end
    check_eq("rst rise", n, EXP_RISE);
    repeat (1000) tick();
    check_eq("rst pre echo", 32'(echo), 1);
    resetn = 1'b0;
    tick();
    check_eq("rst echo", 32'(echo), 0);
    check_eq("rst busy", 32'(busy), 0);
    check_eq("rst count", 32'(ping_count), 0);
    model_count = 0;
    resetn = 1'b1;
    tick();
    valid_ping(10, 12 * F, 1'b0, "post rst");

    // Randomized pings with boundary-biased distances.
    for (int i = 0; i < 14; i++) begin
      int unsigned d;
      int unsigned sel;
      sel = $urandom_range(0, 7);
      case (sel)
        0: d = 0;
        1: d = 1;
        2: d = 400;
        3: d = 401;
        default: d = $urandom_range(0, 511);
      endcase
      repeat ($urandom_range(0, 5)) tick();
      if ($urandom_range(0, 3) == 0) runt_ping($urandom_range(1, 4), "rand runt");
      else valid_ping(d, $urandom_range(9, 20), 1'b0, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #(10 * 200000);
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
